// File: rtl/lshift_deser.sv
// lshift_deser: MSB-first serial-in/parallel-out receiver with valid/ready output and sticky overrun
// Ports: clk, rst (sync, active-high); ser_in/ser_valid serial input; frame_start resync;
//        data_out/data_valid/data_ready output handshake; overrun/overrun_clr sticky drop flag;
//        bit_cnt bits collected in the current word; parity_err only with LSHIFT_DESER_PARITY_EN.
// Option: define LSHIFT_DESER_PARITY_EN to expect an even-parity bit after every word.
module lshift_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             overrun_clr,
`ifdef LSHIFT_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic [CNT_W-1:0] bit_cnt
);
  logic [WIDTH-1:0] sreg_q, sreg_d, dout_q, dout_d, word, hword;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             dv_q, dv_d, ovr_q, ovr_d, shift, wrap, done, load;
`ifdef LSHIFT_DESER_PARITY_EN
  typedef enum logic {COLLECT, PARITY} state_t;
  state_t state_q, state_d;
  logic   perr_q, perr_d, par;
`endif
  always_comb begin
    cnt_base = frame_start ? '0 : cnt_q;
    word     = {sreg_q[WIDTH-2:0], ser_in};
`ifdef LSHIFT_DESER_PARITY_EN
    // frame_start abandons a word still waiting for its parity bit
    par      = (state_q == PARITY) && !frame_start;
    shift    = ser_valid && !par;
    wrap     = shift && (cnt_base == CNT_W'(WIDTH-1));
    done     = par && ser_valid;
    hword    = sreg_q;
    state_d  = (wrap || (par && !ser_valid)) ? PARITY : COLLECT;
`else
    shift    = ser_valid;
    wrap     = shift && (cnt_base == CNT_W'(WIDTH-1));
    done     = wrap;
    hword    = word;
`endif
    cnt_d    = shift ? (wrap ? '0 : cnt_base + CNT_W'(1)) : cnt_base;
    sreg_d   = shift ? word : sreg_q;
    // a finished word is accepted if the holding register is empty or drains this cycle
    load     = done && (!dv_q || data_ready);
    dout_d   = load ? hword : dout_q;
    dv_d     = load || (dv_q && !data_ready);
    ovr_d    = (done && dv_q && !data_ready) || (ovr_q && !overrun_clr);
`ifdef LSHIFT_DESER_PARITY_EN
    perr_d   = load ? ^{sreg_q, ser_in} : perr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef LSHIFT_DESER_PARITY_EN
      perr_q  <= 1'b0;
      state_q <= COLLECT;
`endif
    end else begin
      sreg_q  <= sreg_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
`ifdef LSHIFT_DESER_PARITY_EN
      perr_q  <= perr_d;
      state_q <= state_d;
`endif
    end
  end
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;
`ifdef LSHIFT_DESER_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_lshift_deser.sv
// tb_lshift_deser: directed table-driven bench for lshift_deser (WIDTH=8)
module tb_lshift_deser;
  logic       clk = 1'b0, rst, ser_in, ser_valid, frame_start, data_ready, overrun_clr;
  logic [7:0] data_out;
  logic       data_valid, overrun;
  logic [3:0] bit_cnt;
  int         errs = 0, checks = 0;
`ifdef LSHIFT_DESER_PARITY_EN
  logic       parity_err;
`endif
  always #5 clk = ~clk;
  lshift_deser #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_start(frame_start),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun), .overrun_clr(overrun_clr),
`ifdef LSHIFT_DESER_PARITY_EN
    .parity_err(parity_err),
`endif
    .bit_cnt(bit_cnt)
  );
  typedef struct {
    logic r, fs, v, b, rdy, clr;
    logic [7:0] d;
    logic dv, ov;
    logic [3:0] c;
  } vec_t;
  vec_t q[$];
  function automatic void add(input logic r, fs, v, b, rdy, clr, input logic [7:0] d,
                              input logic dv, ov, input logic [3:0] c);
    vec_t t;
    t = '{r, fs, v, b, rdy, clr, d, dv, ov, c};
    q.push_back(t);
  endfunction
  function automatic void wordv(input logic [7:0] w, input logic rdy, rdy_last, clr_last,
                                input logic [7:0] hd, input logic hdv, hov,
                                input logic [7:0] fd, input logic fdv, fov);
    for (int i = 0; i < 7; i++) add(0, 0, 1, w[7-i], rdy, 0, hd, hdv, hov, 4'(i+1));
    add(0, 0, 1, w[0], rdy_last, clr_last, fd, fdv, fov, 4'd0);
  endfunction
  task automatic drive(input logic r, fs, v, b, rdy, clr);
    @(negedge clk);
    rst = r; frame_start = fs; ser_valid = v; ser_in = b; data_ready = rdy; overrun_clr = clr;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int idx, input logic [31:0] a, e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s at step %0d: got %0h want %0h", n, idx, a, e);
    end
  endtask
  initial begin
    logic [7:0] w;
    rst = 1; frame_start = 0; ser_valid = 0; ser_in = 0; data_ready = 0; overrun_clr = 0;
`ifndef LSHIFT_DESER_PARITY_EN
    add(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    wordv(8'hA5, 1, 1, 0, 8'h00, 0, 0, 8'hA5, 1, 0);
    add(0, 0, 0, 0, 1, 0, 8'hA5, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add(0, 0, 1, 1, 1, 0, 8'hA5, 0, 0, 4'(i));
    add(0, 1, 0, 0, 1, 0, 8'hA5, 0, 0, 0);
    wordv(8'h3C, 1, 1, 0, 8'hA5, 0, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 1, 0, 8'h3C, 0, 0, 0);
    wordv(8'h11, 0, 0, 0, 8'h3C, 0, 0, 8'h11, 1, 0);
    wordv(8'h22, 0, 0, 1, 8'h11, 1, 0, 8'h11, 1, 1);
    add(0, 0, 0, 0, 0, 1, 8'h11, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 8'h11, 0, 0, 0);
    wordv(8'hF0, 0, 0, 0, 8'h11, 0, 0, 8'hF0, 1, 0);
    wordv(8'h0F, 0, 1, 0, 8'hF0, 1, 0, 8'h0F, 1, 0);
    add(0, 0, 0, 0, 1, 0, 8'h0F, 0, 0, 0);
    w = 8'b10110000;
    for (int i = 0; i < 5; i++) add(0, 0, 1, w[7-i], 1, 0, 8'h0F, 0, 0, 4'(i+1));
    add(1, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0);
    wordv(8'h96, 1, 1, 0, 8'h00, 0, 0, 8'h96, 1, 0);
    add(0, 0, 0, 0, 1, 0, 8'h96, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 8'h96, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 8'h96, 0, 0, 2);
    add(0, 1, 1, 1, 1, 0, 8'h96, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 8'h96, 0, 0, 1);
    w = 8'hC3;
    for (int i = 1; i < 7; i++) add(0, 0, 1, w[7-i], 1, 0, 8'h96, 0, 0, 4'(i+1));
    add(0, 0, 1, w[0], 1, 0, 8'hC3, 1, 0, 0);
    foreach (q[i]) begin
      drive(q[i].r, q[i].fs, q[i].v, q[i].b, q[i].rdy, q[i].clr);
      chk("data_out", i, 32'(data_out), 32'(q[i].d));
      chk("data_valid", i, 32'(data_valid), 32'(q[i].dv));
      chk("overrun", i, 32'(overrun), 32'(q[i].ov));
      chk("bit_cnt", i, 32'(bit_cnt), 32'(q[i].c));
    end
    w = 8'h5A;
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, w[7-i], 0, 0);
    begin
      int n = 0;
      while (!data_valid && n < 4) begin drive(0, 0, 0, 0, 0, 0); n++; end
      chk("seq_timeout", 0, 32'(n), 32'd0);
    end
    chk("seq_data", 0, 32'(data_out), 32'h5A);
    drive(0, 0, 0, 0, 0, 0);
    chk("seq_hold", 1, 32'(data_out), 32'h5A);
    chk("seq_hold_valid", 1, 32'(data_valid), 32'd1);
    chk("seq_no_overrun", 1, 32'(overrun), 32'd0);
`else
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_perr", 0, 32'(parity_err), 32'd0);
    w = 8'hA5;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) drive(0, 0, 1, w[7-i], 1, 0);
      chk("par_wait_valid", p, 32'(data_valid), 32'd0);
      chk("par_wait_cnt", p, 32'(bit_cnt), 32'd0);
      drive(0, 0, 1, 1'(p), 1, 0);
      chk("par_valid", p, 32'(data_valid), 32'd1);
      chk("par_data", p, 32'(data_out), 32'hA5);
      chk("par_err", p, 32'(parity_err), 32'(p));
      drive(0, 0, 0, 0, 1, 0);
      chk("par_drop", p, 32'(data_valid), 32'd0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/lshift_deser.md
Name: lshift_deser

Overview:
- Serial-in, parallel-out receiver that sits at the far end of the left-shifting serializer link. The serializer drives its MSB out first; this block rebuilds each word MSB-first.
- Collects WIDTH qualified bits into a shift register, then transfers the word to an output holding register.
- Offers the word to downstream logic with a valid/ready handshake and flags overruns.

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 to 32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  clock; all logic samples on posedge.
- rst  input  1  synchronous reset, active-high.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  qualifies ser_in on the current cycle.
- frame_start  input  1  resynchronise: discard the partial word, restart the bit count.
- data_out  output  WIDTH  received word (holding register).
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  downstream accepts data_out.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  clears overrun.
- bit_cnt  output  CNT_W  bits collected in the current word.

Behaviour:
- Reset: when rst is high at a posedge, the shift register, data_out, data_valid, overrun and bit_cnt all go to 0 and the FSM enters COLLECT. Reset overrides every other input, including mid-word.
- Shift rule: on a cycle with ser_valid=1, sreg <= {sreg[WIDTH-2:0], ser_in} and bit_cnt increments. The first bit received lands in data_out[WIDTH-1].
- frame_start=1:
  - The partial word is discarded and bit_cnt is forced to 0.
  - If ser_valid=1 on the same cycle, that bit is taken as bit 1 of the new word and bit_cnt becomes 1.
- Word completion: on the cycle where bit_cnt==WIDTH-1 and ser_valid=1:
  - The completed word ({sreg[WIDTH-2:0], ser_in}) is handed off.
  - bit_cnt wraps to 0.
  - The next bit may arrive on the very next cycle; no gap is required.
- Handoff latency: data_out and data_valid update on the same posedge that samples the last bit, so they are visible one cycle after the last bit is presented.
- Handshake:
  - A transfer occurs on any cycle with data_valid=1 and data_ready=1. data_valid then falls on the next edge unless a new word completes on that same cycle.
  - data_out is stable while data_valid=1 and data_ready=0.
- Simultaneous completion and transfer: the new word is loaded into data_out and data_valid stays 1. No overrun is flagged.
- Overrun: a word that completes while data_valid=1 and data_ready=0 is dropped. The old data_out is kept and overrun is set.
- Overrun clearing: overrun stays set until overrun_clr. If overrun_clr and a new overrun occur on the same cycle, the set wins.
- data_ready while data_valid=0 has no effect.
- FSM states:
  - COLLECT: accumulates bits.
  - PARITY: exists only when the optional feature is compiled in. Entered after the WIDTH-th data bit; returns to COLLECT after one qualified bit or on frame_start.

Optional Feature:
- Macro: LSHIFT_DESER_PARITY_EN.
- With the macro defined:
  - Each word is followed by one even-parity bit. Handoff happens on the parity-bit cycle, not on the last data bit.
  - Adds output parity_err (1 bit). It is registered alongside data_out and is 1 when XOR(word, parity bit) is not 0.
  - A dropped word does not update parity_err.
  - frame_start while in PARITY discards the word.
- Without the macro: there is no PARITY state, no parity_err port, and the word is handed off on the last data bit.

Test Plan:
- Reset, then shift bits 1,0,1,0,0,1,0,1 with ser_valid=1 on consecutive cycles and data_ready=1 -> data_out=8'hA5 and data_valid=1 on the cycle after the 8th bit, dropping after one cycle; bit_cnt sequence 1..7 then 0.
- Shift 3 bits, pulse frame_start (ser_valid=0), then shift 8'h3C MSB-first -> data_out=8'h3C; the partial bits never appear.
- Hold data_ready=0; send 8'h11 then 8'h22 -> data_out stays 8'h11 and overrun=1. Pulse overrun_clr -> overrun=0. Raise data_ready -> data_valid falls.
- Back-to-back 8'hF0 then 8'h0F with data_ready raised on the cycle 8'h0F completes -> data_out=8'h0F, data_valid stays 1, overrun=0.
- Assert rst after 5 bits of a word -> all outputs 0 next cycle; the following 8 bits form a clean word.
- With LSHIFT_DESER_PARITY_EN: send 8'hA5 + parity 0 -> parity_err=0; send 8'hA5 + parity 1 -> parity_err=1. In both cases data_valid asserts after the 9th bit.
